// File: rtl/snes_vector_hook_if.sv
// SNES B-bus pins seen by the vector hook: address, read strobe and the
// tristated data return path.
interface snes_vector_hook_if;
  logic [7:0] pa;
  logic       pard_n;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output pa, pard_n, input data_out, data_oe);
  modport slave  (input pa, pard_n, output data_out, data_oe);
endinterface

// File: rtl/snes_vector_hook.sv
// Multi-vector hijack engine: per-hook FSMs track lo/hi vector fetches on the
// B-bus and substitute programmable targets; also serves a loadable boot ROM.
module snes_vector_hook_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ev,
  input  logic        hook_en,
  input  logic        arm,
  input  logic [7:0]  pa,
  input  logic [7:0]  pa_s,
  input  logic [7:0]  lo,
  input  logic [15:0] target,
  input  logic        persist,
  output logic        drv,
  output logic [7:0]  drv_data,
  output logic        done,
  output logic        hit
);
  typedef enum logic [1:0] {ARMED, WAIT_HI, WAIT_EXIT, DONE} st_t;
  st_t st, st_nxt;
  logic hit_nxt, drv_lo, drv_hi;
  logic [7:0] hi;

  assign hi = lo + 8'd1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= ARMED;
      hit <= 1'b0;
    end else begin
      st  <= st_nxt;
      hit <= hit_nxt;
    end

  always_comb begin
    st_nxt  = st;
    hit_nxt = 1'b0;
    case (st)
      ARMED:     if (ev && pa_s == lo) st_nxt = WAIT_HI;
      WAIT_HI:   if (ev) begin
                   if (pa_s == hi)      st_nxt = WAIT_EXIT;
                   else if (pa_s != lo) st_nxt = ARMED;
                 end
      WAIT_EXIT: if (ev && pa_s != hi) begin
                   hit_nxt = 1'b1;
                   st_nxt  = persist ? ARMED : DONE;
                 end
      default:   st_nxt = st;
    endcase
    // re-arm and disable override whatever the FSM wanted this cycle
    if (arm || !hook_en) begin
      st_nxt  = ARMED;
      hit_nxt = 1'b0;
    end
  end

  // decode on raw pa so the substitute byte is ready within the same bus cycle
  assign drv_lo   = (st == ARMED || st == WAIT_HI) && pa == lo;
  assign drv_hi   = (st == WAIT_HI || st == WAIT_EXIT) && pa == hi;
  assign drv      = hook_en && (drv_lo || drv_hi);
  assign drv_data = drv_lo ? target[7:0] : target[15:8];
  assign done     = (st == DONE);
endmodule

module snes_vector_hook #(
  parameter int NUM_HOOKS     = 3,
  parameter int ROM_BASE      = 8'h84,
  parameter int ROM_DEPTH     = 124,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  snes_vector_hook_if.slave             bus,
  input  logic                          hook_en,
  input  logic                          arm,
  input  logic [NUM_HOOKS-1:0][7:0]     hook_lo_addr,
  input  logic [NUM_HOOKS-1:0][15:0]    hook_target,
  input  logic [NUM_HOOKS-1:0]          hook_persist,
  input  logic                          rom_we,
  input  logic [7:0]                    rom_waddr,
  input  logic [7:0]                    rom_wdata,
  output logic [NUM_HOOKS-1:0]          hook_done,
  output logic [NUM_HOOKS-1:0]          hook_hit
);
  localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][7:0] pa_sync;
  logic [7:0]    pa_s, pa_prev, last_addr;
  logic [CW-1:0] stab_cnt;
  logic          chg, ev;

  assign pa_s = pa_sync[SYNC_STAGES-1];
  assign chg  = pa_s != pa_prev;
  assign ev   = !chg && stab_cnt == STAB_MAX && pa_s != last_addr;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pa_sync   <= '0;
      pa_prev   <= 8'h00;
      stab_cnt  <= '0;
      last_addr <= 8'h00;
    end else begin
      pa_sync[0] <= bus.pa;
      for (int i = 1; i < SYNC_STAGES; i++) pa_sync[i] <= pa_sync[i-1];
      pa_prev <= pa_s;
      if (chg)                        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)  stab_cnt <= stab_cnt + CW'(1);
      if (ev) last_addr <= pa_s;
    end

  // boot ROM storage is not reset; contents are loaded through rom_we
  logic [7:0]    rom [ROM_DEPTH];
  logic [AW-1:0] ridx;
  logic          in_rom;

  always_ff @(posedge clk)
    if (rom_we && {1'b0, rom_waddr} < 9'(ROM_DEPTH))
      rom[AW'(rom_waddr)] <= rom_wdata;

  assign in_rom = {1'b0, bus.pa} >= 9'(ROM_BASE) &&
                  {1'b0, bus.pa} <  9'(ROM_BASE + ROM_DEPTH);
  assign ridx   = AW'(bus.pa - 8'(ROM_BASE));

  logic [NUM_HOOKS-1:0]      drv;
  logic [NUM_HOOKS-1:0][7:0] drv_data;

  for (genvar g = 0; g < NUM_HOOKS; g++) begin : g_lane
    snes_vector_hook_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .ev       (ev),
      .hook_en  (hook_en),
      .arm      (arm),
      .pa       (bus.pa),
      .pa_s     (pa_s),
      .lo       (hook_lo_addr[g]),
      .target   (hook_target[g]),
      .persist  (hook_persist[g]),
      .drv      (drv[g]),
      .drv_data (drv_data[g]),
      .done     (hook_done[g]),
      .hit      (hook_hit[g])
    );
  end

  // walk downward so the lowest-index matching hook has the last word
  always_comb begin
    bus.data_out = 8'h00;
    bus.data_oe  = 1'b0;
    if (!bus.pard_n && in_rom) begin
      bus.data_out = rom[ridx];
      bus.data_oe  = 1'b1;
    end
    for (int i = NUM_HOOKS - 1; i >= 0; i--)
      if (drv[i]) begin
        bus.data_out = drv_data[i];
        bus.data_oe  = 1'b1;
      end
  end
endmodule
